// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 average-pooling scheduler.
// Holds the pixel/accumulator widths, FSM encoding and buffer address arithmetic.
package pool_pkg;

    localparam int DATA_W = 16;
    localparam int ACC_W  = DATA_W + 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RD3  = 3'd4,
        LAST = 3'd5,
        WR   = 3'd6,
        DONE = 3'd7
    } state_t;

    // Linear offset of (row, col) in a row-major map of the given side.
    function automatic int unsigned grid_addr(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned side);
        return row * side + col;
    endfunction

endpackage

// File: rtl/pool_avg4_acc.sv
// Four-pixel accumulator for one pooling window; the average is the sum
// with the two LSBs dropped, so four full-scale pixels never overflow.
module pool_avg4_acc
    import pool_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] avg
);

    logic [ACC_W-1:0] acc_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p1 <= '0;
        end else if (clr) begin
            acc_p1 <= '0;
        end else if (add) begin
            acc_p1 <= acc_p1 + ACC_W'(din);
        end
    end

    assign avg = acc_p1[ACC_W-1:2];

endmodule

// File: rtl/pool2x2_scheduler.sv
// Walks a square feature map in 2x2 stride-2 windows, fetching four pixels per
// window from the input buffer and writing one averaged pixel to the output buffer.
module pool2x2_scheduler
    import pool_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MAX_IMG  = 28,
    parameter int ADDR_W   = 10,
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = 0
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [5:0]        img_size,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready
);

    localparam logic [5:0] MAX_S = 6'(MAX_IMG);

    state_t            state;
    logic [5:0]        se;
    logic [4:0]        o_side;
    logic [4:0]        r;
    logic [4:0]        c;

    logic [5:0]        se_in;
    logic [4:0]        o_in;
    logic              row_end;
    logic              last_win;
    logic [4:0]        r_nxt;
    logic [4:0]        c_nxt;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] base_nxt;
    logic [ADDR_W-1:0] out_addr;
    logic              acc_clr;
    logic              acc_add;

    always_comb begin
        se_in    = (img_size > MAX_S) ? MAX_S : img_size;
        o_in     = se_in[5:1];
        row_end  = (c == o_side - 5'd1);
        last_win = row_end && (r == o_side - 5'd1);
        c_nxt    = row_end ? 5'd0 : c + 5'd1;
        r_nxt    = row_end ? r + 5'd1 : r;
        // Window origin is (2r, 2c) in input-pixel coordinates.
        base     = ADDR_W'(IN_BASE + grid_addr(2 * 32'(r), 2 * 32'(c), 32'(se)));
        base_nxt = ADDR_W'(IN_BASE + grid_addr(2 * 32'(r_nxt), 2 * 32'(c_nxt), 32'(se)));
        out_addr = ADDR_W'(OUT_BASE + grid_addr(32'(r), 32'(c), 32'(o_side)));
        acc_clr  = (state == RD0);
        acc_add  = (state == RD1) || (state == RD2) || (state == RD3) || (state == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            se      <= '0;
            o_side  <= '0;
            r       <= '0;
            c       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        se     <= se_in;
                        o_side <= o_in;
                        if (o_in == 5'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            r       <= '0;
                            c       <= '0;
                            state   <= RD0;
                            busy    <= 1'b1;
                            rd_en   <= 1'b1;
                            rd_addr <= ADDR_W'(IN_BASE);
                        end
                    end
                end
                RD0: begin
                    state   <= RD1;
                    rd_addr <= base + ADDR_W'(1);
                end
                RD1: begin
                    state   <= RD2;
                    rd_addr <= base + ADDR_W'(se);
                end
                RD2: begin
                    state   <= RD3;
                    rd_addr <= base + ADDR_W'(se) + ADDR_W'(1);
                end
                RD3: begin
                    state <= LAST;
                    rd_en <= 1'b0;
                end
                LAST: begin
                    state   <= WR;
                    wr_en   <= 1'b1;
                    wr_addr <= out_addr;
                end
                WR: begin
                    // Address and data hold until the output buffer accepts.
                    if (wr_ready) begin
                        wr_en <= 1'b0;
                        if (last_win) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            r       <= r_nxt;
                            c       <= c_nxt;
                            state   <= RD0;
                            rd_en   <= 1'b1;
                            rd_addr <= base_nxt;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    pool_avg4_acc u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .add   (acc_add),
        .din   (rd_data),
        .avg   (wr_data)
    );

endmodule

// File: tb/tb_pool2x2_scheduler.sv
// Directed bench for pool2x2_scheduler: table of pooling passes with expected
// writes and done latency, plus hand sequences for reset and read-address cases.
module tb_pool2x2_scheduler;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [5:0]        img_size;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    logic [DATA_W-1:0] mem [0:1023];

    pool2x2_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .img_size (img_size),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready)
    );

    always #5 clk = ~clk;

    // One-cycle read latency input buffer.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    typedef struct {
        int size;
        int pat;
        int stall_idx;
        int mid_start;
        int nwr;
        int lat;
        int d0;
        int d1;
        int d2;
        int d3;
    } vec_t;

    vec_t vecs [0:7];
    int   nvec  = 0;
    int   nfail = 0;
    int   wa[$];
    int   wd[$];
    int   ra[$];
    int   both_hi;
    int   busy_cnt;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int pat);
        for (int i = 0; i < 1024; i++) mem[i] = (pat == 1) ? 16'hFFFF : 16'(i);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},    int'(busy),    0);
        chk({tag, "_done"},    int'(done),    0);
        chk({tag, "_rd_en"},   int'(rd_en),   0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_wr_en"},   int'(wr_en),   0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
        chk({tag, "_wr_data"}, int'(wr_data), 0);
    endtask

    // Runs one pass; k counts cycles after the start-sampling edge.
    task automatic run_pass(input int size, input int stall_idx, input int stall_n,
                            input int hold_data, input int mid_start, output int lat);
        int stall_left;
        wa.delete(); wd.delete(); ra.delete();
        both_hi = 0; busy_cnt = 0; lat = -1; stall_left = stall_n;
        @(negedge clk);
        start = 1'b1; img_size = 6'(size);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 3000 && lat < 0; k++) begin
            if (k > 1) @(negedge clk);
            start = (mid_start != 0 && k == 10);
            if (mid_start != 0 && k == 10) img_size = 6'd2;
            if (wr_en && wa.size() == stall_idx && stall_left > 0) begin
                wr_ready = 1'b0;
                stall_left--;
                chk("hold_wr_en",   int'(wr_en),   1);
                chk("hold_wr_addr", int'(wr_addr), stall_idx);
                chk("hold_wr_data", int'(wr_data), hold_data);
                chk("hold_no_read", int'(rd_en),   0);
            end else begin
                wr_ready = 1'b1;
            end
            if (wr_en && wr_ready) begin
                wa.push_back(int'(wr_addr));
                wd.push_back(int'(wr_data));
            end
            if (rd_en) ra.push_back(int'(rd_addr));
            if (rd_en && wr_en) both_hi++;
            if (busy) busy_cnt++;
            if (done) lat = k;
        end
        start = 1'b0;
        wr_ready = 1'b1;
        if (lat < 0) chk("done_timeout", lat, 0);
        @(negedge clk);
        chk("done_pulse_width", int'(done), 0);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   lat;
        int   exp_d [4];
        v = vecs[idx];
        exp_d[0] = v.d0; exp_d[1] = v.d1; exp_d[2] = v.d2; exp_d[3] = v.d3;
        fill(v.pat);
        run_pass(v.size, v.stall_idx, 3, (v.stall_idx >= 0) ? exp_d[v.stall_idx] : 0,
                 v.mid_start, lat);
        chk($sformatf("v%0d_done_lat", idx), lat, v.lat);
        chk($sformatf("v%0d_nwr", idx), wa.size(), v.nwr);
        chk($sformatf("v%0d_busy_cycles", idx), busy_cnt, v.lat - 1);
        chk($sformatf("v%0d_rd_wr_overlap", idx), both_hi, 0);
        for (int j = 0; j < 4 && j < wa.size(); j++) begin
            chk($sformatf("v%0d_w%0d_addr", idx, j), wa[j], j);
            chk($sformatf("v%0d_w%0d_data", idx, j), wd[j], exp_d[j]);
        end
        if (v.nwr == 0) chk($sformatf("v%0d_no_reads", idx), ra.size(), 0);
    endtask

    initial begin
        int bad;
        int lat;
        vecs[0] = '{4,  0, -1, 0, 4,   25,   2,     4,  10, 12};
        vecs[1] = '{2,  1, -1, 0, 1,   7,    65535, 0,  0,  0};
        vecs[2] = '{5,  0, -1, 0, 4,   25,   3,     5,  13, 15};
        vecs[3] = '{4,  0,  1, 0, 4,   28,   2,     4,  10, 12};
        vecs[4] = '{4,  0, -1, 1, 4,   25,   2,     4,  10, 12};
        vecs[5] = '{1,  0, -1, 0, 0,   1,    0,     0,  0,  0};
        vecs[6] = '{0,  0, -1, 0, 0,   1,    0,     0,  0,  0};
        vecs[7] = '{63, 0, -1, 0, 196, 1177, 14,    16, 18, 20};

        rst_n = 1'b0; start = 1'b0; img_size = 6'd0; wr_ready = 1'b1;
        fill(0);
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i);

        // Odd map side: window (0,1) reads and the dropped last row/column.
        fill(0);
        run_pass(5, -1, 0, 0, 0, lat);
        chk("s5_nreads", ra.size(), 16);
        if (ra.size() >= 8) begin
            chk("s5_w1_rd0", ra[4], 2);
            chk("s5_w1_rd1", ra[5], 3);
            chk("s5_w1_rd2", ra[6], 7);
            chk("s5_w1_rd3", ra[7], 8);
        end
        bad = 0;
        foreach (ra[i]) if ((ra[i] % 5) == 4 || (ra[i] / 5) == 4) bad++;
        chk("s5_edge_reads", bad, 0);

        // Async reset during RD2 of the second window.
        fill(0);
        @(negedge clk);
        start = 1'b1; img_size = 6'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_pre_rd_en",   int'(rd_en),   1);
        chk("rst_pre_rd_addr", int'(rd_addr), 6);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1, "global timeout");
    end

endmodule
